// File: rtl/program_loader_ctrl.sv
// ---------------------------------------------------------------------------
// program_loader_ctrl
// Purpose : drives the programming/execution interface of the multi-cycle
//           datapath. It streams a program into the unified cache while pmode=1,
//           then boots the core at entry_pc and runs it for a bounded or
//           unbounded number of cycles. When the run ends it re-freezes the
//           core by setting pmode back to 1.
// Ports   :
//   clk, reset            clock; asynchronous active-low reset
//   start                 one-cycle request, honoured in IDLE/DONE only
//   base_addr/word_count  load window (word_count=0 skips the load)
//   entry_pc/run_limit    boot PC and RUN length (run_limit=0 = unlimited)
//   halt                  ends RUN after the current cycle
//   in_valid/in_data/in_ready  program word stream (valid/ready)
//   dp_pmode/dp_addr/dp_program/dp_init_PC/dp_reset  datapath controls
//   busy/done/cycles      status
// ---------------------------------------------------------------------------
module program_loader_ctrl #(
   parameter int unsigned N        = 32,
   parameter int unsigned CNT_W    = 16,
   parameter int unsigned BOOT_CYC = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [N-1:0]     base_addr,
   input  logic [CNT_W-1:0] word_count,
   input  logic [N-1:0]     entry_pc,
   input  logic [CNT_W-1:0] run_limit,
   input  logic             halt,
   input  logic             in_valid,
   input  logic [N-1:0]     in_data,
   output logic             in_ready,
   output logic             dp_pmode,
   output logic [N-1:0]     dp_addr,
   output logic [N-1:0]     dp_program,
   output logic [N-1:0]     dp_init_PC,
   output logic             dp_reset,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] cycles
);

   localparam int unsigned       BOOT_W    = (BOOT_CYC > 1) ? $clog2(BOOT_CYC) : 1;
   localparam logic [BOOT_W-1:0] BOOT_LAST = BOOT_W'(BOOT_CYC - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_BOOT,
      S_RUN,
      S_DONE
   } state_e;

   state_e             state_q,   state_d;
   logic [N-1:0]       base_q,    base_d;
   logic [CNT_W-1:0]   count_q,   count_d;
   logic [CNT_W-1:0]   limit_q,   limit_d;
   logic [CNT_W-1:0]   index_q,   index_d;
   logic [CNT_W-1:0]   cycles_q,  cycles_d;
   logic [BOOT_W-1:0]  boot_q,    boot_d;
   logic [N-1:0]       addr_q,    addr_d;
   logic [N-1:0]       prog_q,    prog_d;
   logic [N-1:0]       pc_q,      pc_d;
   logic               pmode_q,   pmode_d;
   logic               dprst_q,   dprst_d;
   logic [CNT_W-1:0]   cyc_inc;

   // Saturating RUN cycle increment; also used for the limit compare so that
   // RUN lasts exactly run_limit cycles.
   assign cyc_inc = (cycles_q == CNT_MAX) ? CNT_MAX : cycles_q + CNT_W'(1);

   // Next-state and next-output logic
   always_comb begin
      state_d  = state_q;
      base_d   = base_q;
      count_d  = count_q;
      limit_d  = limit_q;
      index_d  = index_q;
      cycles_d = cycles_q;
      boot_d   = boot_q;
      addr_d   = addr_q;
      prog_d   = prog_q;
      pc_d     = pc_q;

      unique case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               base_d   = base_addr;
               count_d  = word_count;
               limit_d  = run_limit;
               pc_d     = entry_pc;
               cycles_d = '0;
               index_d  = '0;
               boot_d   = '0;
               state_d  = (word_count != '0) ? S_LOAD : S_BOOT;
            end
         end
         S_LOAD: begin
            // Address/data only move on a handshake, so the continuous cache
            // write while pmode=1 just rewrites the last word unchanged.
            if (in_valid) begin
               addr_d  = base_q + N'(index_q);
               prog_d  = in_data;
               index_d = index_q + CNT_W'(1);
               if (index_q == count_q - CNT_W'(1)) begin
                  boot_d  = '0;
                  state_d = S_BOOT;
               end
            end
         end
         S_BOOT: begin
            if (boot_q == BOOT_LAST) begin
               state_d = S_RUN;
            end else begin
               boot_d = boot_q + BOOT_W'(1);
            end
         end
         S_RUN: begin
            cycles_d = cyc_inc;
            if (halt || ((limit_q != '0) && (cyc_inc == limit_q))) begin
               state_d = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Datapath controls follow the state being entered so they line up with it
      pmode_d = !((state_d == S_BOOT) || (state_d == S_RUN));
      dprst_d = (state_d == S_BOOT);
   end

   // State and output registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         base_q   <= '0;
         count_q  <= '0;
         limit_q  <= '0;
         index_q  <= '0;
         cycles_q <= '0;
         boot_q   <= '0;
         addr_q   <= '0;
         prog_q   <= '0;
         pc_q     <= '0;
         pmode_q  <= 1'b1;
         dprst_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         base_q   <= base_d;
         count_q  <= count_d;
         limit_q  <= limit_d;
         index_q  <= index_d;
         cycles_q <= cycles_d;
         boot_q   <= boot_d;
         addr_q   <= addr_d;
         prog_q   <= prog_d;
         pc_q     <= pc_d;
         pmode_q  <= pmode_d;
         dprst_q  <= dprst_d;
      end
   end

   // Status decoded from state; datapath controls come straight from registers
   assign in_ready   = (state_q == S_LOAD);
   assign busy       = (state_q == S_LOAD) || (state_q == S_BOOT) || (state_q == S_RUN);
   assign done       = (state_q == S_DONE);
   assign dp_pmode   = pmode_q;
   assign dp_reset   = dprst_q;
   assign dp_addr    = addr_q;
   assign dp_program = prog_q;
   assign dp_init_PC = pc_q;
   assign cycles     = cycles_q;

endmodule

// File: tb/tb_program_loader_ctrl.sv
// ---------------------------------------------------------------------------
// tb_program_loader_ctrl
// Purpose : self-checking bench for program_loader_ctrl. A table of program
//           scenarios is applied in a loop; cache writes are predicted into a
//           scoreboard queue at handshake time and popped one cycle later.
//           Hand-written sequences cover reset and reset during LOAD.
// ---------------------------------------------------------------------------
module tb_program_loader_ctrl;

   localparam int unsigned N     = 32;
   localparam int unsigned CNT_W = 16;

   logic             clk = 1'b0;
   logic             reset;
   logic             start;
   logic [N-1:0]     base_addr;
   logic [CNT_W-1:0] word_count;
   logic [N-1:0]     entry_pc;
   logic [CNT_W-1:0] run_limit;
   logic             halt;
   logic             in_valid;
   logic [N-1:0]     in_data;
   logic             in_ready;
   logic             dp_pmode;
   logic [N-1:0]     dp_addr;
   logic [N-1:0]     dp_program;
   logic [N-1:0]     dp_init_PC;
   logic             dp_reset;
   logic             busy;
   logic             done;
   logic [CNT_W-1:0] cycles;

   program_loader_ctrl #(.N(N), .CNT_W(CNT_W), .BOOT_CYC(2)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .base_addr  (base_addr),
      .word_count (word_count),
      .entry_pc   (entry_pc),
      .run_limit  (run_limit),
      .halt       (halt),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .dp_pmode   (dp_pmode),
      .dp_addr    (dp_addr),
      .dp_program (dp_program),
      .dp_init_PC (dp_init_PC),
      .dp_reset   (dp_reset),
      .busy       (busy),
      .done       (done),
      .cycles     (cycles)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [N-1:0]     base;
      logic [CNT_W-1:0] count;
      logic [N-1:0]     dbase;
      logic [N-1:0]     entry;
      logic [CNT_W-1:0] limit;
      int               halt_at;   // RUN cycle (1-based) carrying halt, 0 = none
      logic [7:0]       vpat;      // in_valid pattern, bit i = cycle i
      int               vlen;
      bit               idle_valid; // hold in_valid high outside LOAD
      int               exp_run;   // expected RUN cycles and final cycles value
   } vec_t;

   typedef struct {
      logic [N-1:0] a;
      logic [N-1:0] d;
   } wr_t;

   vec_t vecs[5];
   wr_t  sb[$];
   int   tests = 0;
   int   fails = 0;
   logic [N-1:0] exp_addr = '0;
   logic [N-1:0] exp_prog = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic pop_check();
      wr_t w;
      if (sb.size() != 0) begin
         w = sb.pop_front();
         exp_addr = w.a;
         exp_prog = w.d;
         check("dp_addr_write", dp_addr, w.a);
         check("dp_program_write", dp_program, w.d);
      end
   endtask

   task automatic run_case(input int ci, input vec_t v);
      int unsigned sent;
      int          cyc;
      int          boot_n;
      int          run_n;
      logic        vb;
      // issue start
      base_addr  = v.base;
      word_count = v.count;
      entry_pc   = v.entry;
      run_limit  = v.limit;
      start      = 1'b1;
      in_valid   = v.idle_valid;
      in_data    = 32'hBAD0_0000;
      @(negedge clk);
      start = 1'b0;
      check("busy_after_start", busy, 1'b1);
      check("dp_init_PC", dp_init_PC, v.entry);

      // LOAD: predicted writes go to the scoreboard at handshake time
      sent = 0;
      cyc  = 0;
      while (sent < int'(v.count) && cyc < 200) begin
         pop_check();
         check("in_ready_load", in_ready, 1'b1);
         check("pmode_load", dp_pmode, 1'b1);
         vb       = v.vpat[cyc % v.vlen];
         in_valid = vb;
         in_data  = v.dbase + N'(sent);
         if (vb) begin
            sb.push_back('{a: v.base + N'(sent), d: v.dbase + N'(sent)});
            sent++;
         end
         cyc++;
         @(negedge clk);
      end
      in_valid = v.idle_valid;
      check("load_words_sent", 64'(sent), 64'(v.count));
      pop_check();

      // BOOT: first cycle after last transfer (or after start when count=0)
      boot_n = 0;
      while (dp_reset === 1'b1 && boot_n < 20) begin
         boot_n++;
         check("pmode_boot", dp_pmode, 1'b0);
         check("in_ready_boot", in_ready, 1'b0);
         @(negedge clk);
      end
      check("boot_cycles", 64'(boot_n), 64'd2);

      // RUN: cycles shows completed RUN cycles; a stray start is driven in cycle 2
      run_n = 0;
      while (busy === 1'b1 && done === 1'b0 && run_n < 300) begin
         run_n++;
         check("cycles_run", cycles, 64'(run_n - 1));
         if (run_n == 1) check("pmode_run", dp_pmode, 1'b0);
         if (run_n == 1) check("dp_reset_run", dp_reset, 1'b0);
         halt  = (run_n == v.halt_at);
         start = (run_n == 2);
         if (run_n == 2) begin
            base_addr  = 32'h5555_0000;
            word_count = 16'd7;
            entry_pc   = 32'h7777_7777;
            run_limit  = 16'd1;
         end
         @(negedge clk);
      end
      halt  = 1'b0;
      start = 1'b0;
      check("run_length", 64'(run_n), 64'(v.exp_run));
      check("done_flag", done, 1'b1);
      check("busy_done", busy, 1'b0);
      check("pmode_done", dp_pmode, 1'b1);
      check("cycles_done", cycles, 64'(v.exp_run));
      check("dp_addr_hold", dp_addr, exp_addr);
      check("dp_init_PC_kept", dp_init_PC, v.entry);
      @(negedge clk);
      check("done_stays", done, 1'b1);
      check("cycles_hold", cycles, 64'(v.exp_run));
      check("in_ready_done", in_ready, 1'b0);
      in_valid = 1'b0;
      if (ci < 0) $display("unreachable");
   endtask

   initial begin
      // base, count, dbase, entry, limit, halt_at, vpat, vlen, idle_valid, exp_run
      vecs[0] = '{32'h0000_0010, 16'd4, 32'h0000_00A0, 32'h0000_0040, 16'd5, 0, 8'b0010_1101, 6, 1'b0, 5};
      vecs[1] = '{32'h0000_0200, 16'd3, 32'h1234_0000, 32'h0000_0100, 16'd0, 9, 8'b0000_0001, 1, 1'b0, 9};
      vecs[2] = '{32'h0000_0300, 16'd2, 32'hCAFE_0000, 32'h0000_0200, 16'd6, 6, 8'b0000_0110, 3, 1'b0, 6};
      vecs[3] = '{32'h0000_0400, 16'd0, 32'h0000_0000, 32'h0000_0300, 16'd3, 0, 8'b0000_0001, 1, 1'b1, 3};
      vecs[4] = '{32'hFFFF_FFFF, 16'd2, 32'hBEEF_0000, 32'h0000_0400, 16'd1, 0, 8'b0000_0001, 1, 1'b0, 1};

      reset      = 1'b0;
      start      = 1'b0;
      base_addr  = '0;
      word_count = '0;
      entry_pc   = '0;
      run_limit  = '0;
      halt       = 1'b0;
      in_valid   = 1'b0;
      in_data    = '0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("rst_pmode", dp_pmode, 1'b1);
      check("rst_addr", dp_addr, '0);
      check("rst_program", dp_program, '0);
      check("rst_init_pc", dp_init_PC, '0);
      check("rst_dp_reset", dp_reset, 1'b0);
      check("rst_in_ready", in_ready, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_cycles", cycles, '0);

      for (int i = 0; i < 5; i++) run_case(i, vecs[i]);
      check("sb_empty", 64'(sb.size()), 64'd0);

      // Reset in the middle of LOAD takes effect without a clock edge
      base_addr  = 32'h0000_0800;
      word_count = 16'd4;
      entry_pc   = 32'h0000_0500;
      run_limit  = 16'd2;
      start      = 1'b1;
      @(negedge clk);
      start    = 1'b0;
      in_valid = 1'b1;
      in_data  = 32'h0000_00E0;
      @(negedge clk);
      in_valid = 1'b0;
      check("midload_write_addr", dp_addr, 32'h0000_0800);
      check("midload_write_data", dp_program, 32'h0000_00E0);
      check("midload_in_ready", in_ready, 1'b1);
      #2 reset = 1'b0;
      #1;
      check("async_rst_in_ready", in_ready, 1'b0);
      check("async_rst_busy", busy, 1'b0);
      check("async_rst_addr", dp_addr, '0);
      check("async_rst_program", dp_program, '0);
      check("async_rst_pmode", dp_pmode, 1'b1);
      check("async_rst_init_pc", dp_init_PC, '0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("post_rst_idle", busy, 1'b0);
      check("post_rst_done", done, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
